// File: rtl/reg_alu_seq_if.sv
// Bundle between the sequencer and its surroundings: program load port,
// run control/status, and the control/data lines that drive reg_alu.
interface reg_alu_seq_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter int PC_W   = 4
);
    logic              start;
    logic              prog_we;
    logic [PC_W-1:0]   prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              sel;
    logic              wr;
    logic [1:0]        op;
    logic [RA_W-1:0]   rd_addr_a;
    logic [RA_W-1:0]   rd_addr_b;
    logic [RA_W-1:0]   wr_addr;
    logic [DATA_W-1:0] d_in;
    logic              busy;
    logic              done;
    logic [PC_W-1:0]   pc;

    modport master (
        output start, prog_we, prog_addr, prog_data,
        input  sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, busy, done, pc
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data,
        output sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, busy, done, pc
    );
endinterface

// File: rtl/reg_alu_seq.sv
// Programmable sequencer for reg_alu: fetches 16-bit words from a 16-entry
// program memory and issues one LDI/ALU register write per instruction until HALT.
module reg_alu_seq #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter int PC_W   = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    reg_alu_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, IMM, EXEC, DONE} state_e;

    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_HALT = 4'hF;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    // Bits [2:0] of the instruction are never used, so they are not stored.
    logic [DATA_W-1:3] ir_q, ir_d;
    logic [DATA_W-1:0] mem_q [2**PC_W];
    logic [DATA_W-1:0] mem_rd;

    logic              sel, wr;
    logic [1:0]        op;
    logic [DATA_W-1:0] d_in;
    logic              busy;

    assign busy   = (state_q != IDLE);
    assign mem_rd = mem_q[pc_q];

    // Program memory has no reset so a loaded program survives reset.
    always_ff @(posedge clk_i) begin
        if (bus.prog_we && !busy)
            mem_q[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        sel     = 1'b0;
        wr      = 1'b0;
        op      = 2'b00;
        d_in    = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = mem_rd[DATA_W-1:3];
                pc_d    = pc_q + PC_W'(1);
                state_d = DECODE;
            end
            DECODE: begin
                if (ir_q[15:12] == OPC_HALT)     state_d = DONE;
                else if (ir_q[15:12] == OPC_LDI) state_d = IMM;
                else if (ir_q[15:14] == 2'b01)   state_d = EXEC;
                else                             state_d = FETCH;
            end
            IMM: begin
                // Immediate is the word after the LDI; pc wraps naturally at 15.
                d_in    = mem_rd;
                wr      = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = FETCH;
            end
            EXEC: begin
                sel     = 1'b1;
                wr      = 1'b1;
                op      = ir_q[13:12];
                state_d = FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel       = sel;
    assign bus.wr        = wr;
    assign bus.op        = op;
    assign bus.d_in      = d_in;
    assign bus.wr_addr   = ir_q[11:9];
    assign bus.rd_addr_a = ir_q[8:6];
    assign bus.rd_addr_b = ir_q[5:3];
    assign bus.busy      = busy;
    assign bus.done      = (state_q == DONE);
    assign bus.pc        = pc_q;
endmodule

// File: tb/tb_reg_alu_seq.sv
// Bench for reg_alu_seq: instruction-level reference model produces an expected
// per-cycle trace that is compared against the DUT for directed and random programs.
module tb_reg_alu_seq;
    localparam int MAXC = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_alu_seq_if bus ();
    reg_alu_seq dut (.clk_i(clk), .reset_i(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem_m [16];
    logic [34:0] expv [MAXC];
    logic [34:0] got  [MAXC];

    // {busy, done, wr, sel, op, wr_addr, rd_a, rd_b, d_in, pc}; fields the spec
    // leaves open (op during IMM, d_in during EXEC, addresses when not writing) masked.
    function automatic logic [34:0] pk(input bit b, input bit dn, input bit w, input bit s,
                                       input logic [1:0] o, input logic [2:0] wa,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [15:0] d, input logic [3:0] p);
        logic [1:0] om;
        logic [8:0] am;
        logic [15:0] dm;
        om = (w && !s) ? 2'b00 : o;
        am = w ? {wa, ra, rb} : 9'b0;
        dm = (w && s) ? 16'h0 : d;
        return {b, dn, w, s, om, am, dm, p};
    endfunction

    function automatic logic [34:0] obs();
        return pk(bus.busy, bus.done, bus.wr, bus.sel, bus.op, bus.wr_addr,
                  bus.rd_addr_a, bus.rd_addr_b, bus.d_in, bus.pc);
    endfunction

    // Instruction-level model: NOP 2 cycles, LDI/ALU 3 (write in the 3rd), HALT 3 then idle.
    task automatic model(input int n);
        int t, p, p1;
        bit halted;
        logic [15:0] w;
        t = 0; p = 0; halted = 0;
        for (int i = 0; i < MAXC; i++) expv[i] = '0;
        while (t < n && !halted) begin
            w  = mem_m[p];
            p1 = (p + 1) % 16;
            expv[t] = pk(1, 0, 0, 0, 2'b0, 3'b0, 3'b0, 3'b0, 16'h0, p[3:0]); t++;
            if (t < n) expv[t] = pk(1, 0, 0, 0, 2'b0, 3'b0, 3'b0, 3'b0, 16'h0, p1[3:0]);
            t++;
            if (w[15:12] == 4'hF) begin
                if (t < n) expv[t] = pk(1, 1, 0, 0, 2'b0, 3'b0, 3'b0, 3'b0, 16'h0, p1[3:0]);
                t++;
                for (; t < n; t++) expv[t] = pk(0, 0, 0, 0, 2'b0, 3'b0, 3'b0, 3'b0, 16'h0, p1[3:0]);
                halted = 1;
            end else if (w[15:12] == 4'h1) begin
                if (t < n) expv[t] = pk(1, 0, 1, 0, 2'b0, w[11:9], w[8:6], w[5:3], mem_m[p1], p1[3:0]);
                t++;
                p = (p1 + 1) % 16;
            end else if (w[15:14] == 2'b01) begin
                if (t < n) expv[t] = pk(1, 0, 1, 1, w[13:12], w[11:9], w[8:6], w[5:3], 16'h0, p1[3:0]);
                t++;
                p = p1;
            end else begin
                p = p1;
            end
        end
    endtask

    task automatic load();
        for (int a = 0; a < 16; a++) begin
            bus.prog_we = 1'b1; bus.prog_addr = a[3:0]; bus.prog_data = mem_m[a];
            @(posedge clk); #1;
        end
        bus.prog_we = 1'b0;
    endtask

    // mode 1: write attempts to address 0 while busy; mode 2: start pulses while busy
    task automatic run(input int n, input int mode);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            got[t] = obs();
            if (mode == 1) begin
                bus.prog_we = (t >= 1 && t <= 6); bus.prog_addr = 4'd0; bus.prog_data = 16'hF000;
            end
            if (mode == 2) bus.start = (t == 3 || t == 6 || t == 9);
        end
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic spec_prog();
        for (int a = 0; a < 16; a++) mem_m[a] = 16'h0000;
        mem_m[0] = 16'h1600; mem_m[1] = 16'hCDEF; mem_m[2] = 16'h1E00;
        mem_m[3] = 16'h3210; mem_m[4] = 16'h4AF8; mem_m[5] = 16'hF000;
    endtask

    task automatic test_reset();
        logic [34:0] o;
        @(negedge clk);
        o = {bus.busy, bus.done, bus.wr, bus.sel, bus.op, bus.wr_addr, bus.rd_addr_a,
             bus.rd_addr_b, bus.d_in, bus.pc};
        n_cmp++;
        if (o !== 35'h0) begin
            n_bad++; $display("FAIL reset_state got=%h exp=0", o);
        end
        reset = 1'b0;
    endtask

    task automatic test_program();
        int nw;
        spec_prog(); load(); model(16); run(16, 0);
        nw = 0;
        for (int t = 0; t < 16; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL prog_trace t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
            if (got[t][32]) nw++;
        end
        n_cmp++;
        if (nw != 3) begin n_bad++; $display("FAIL prog_wr_count got=%0d exp=3", nw); end
        n_cmp++;
        if (got[11][33] !== 1'b1 || got[12][34] !== 1'b0) begin
            n_bad++; $display("FAIL prog_done_timing done11=%b busy12=%b exp 1/0", got[11][33], got[12][34]);
        end
        n_cmp++;
        if (got[8][31:29] !== 3'b100 || got[8][28:26] !== 3'd5) begin
            n_bad++; $display("FAIL prog_add got sel/op=%b addr=%0d exp 100/5", got[8][31:29], got[8][28:26]);
        end
    endtask

    task automatic test_prog_we_busy();
        spec_prog(); model(16); run(16, 1);
        for (int t = 0; t < 16; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL we_busy_run t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
        end
        run(16, 0);
        for (int t = 0; t < 16; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL we_busy_rerun t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
        end
    endtask

    task automatic test_start_busy();
        spec_prog(); model(16); run(16, 2);
        for (int t = 0; t < 16; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL start_busy t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
        end
    endtask

    task automatic test_reset_exec();
        logic [34:0] o;
        spec_prog(); model(16);
        bus.start = 1'b1; @(posedge clk); #1; bus.start = 1'b0;
        for (int t = 0; t <= 8; t++) @(negedge clk);
        n_cmp++;
        if (bus.wr !== 1'b1 || bus.sel !== 1'b1) begin
            n_bad++; $display("FAIL rst_exec_pre wr=%b sel=%b exp 1/1", bus.wr, bus.sel);
        end
        reset = 1'b1;
        #1;
        o = {bus.busy, bus.done, bus.wr, bus.sel, bus.op, bus.wr_addr, bus.rd_addr_a,
             bus.rd_addr_b, bus.d_in, bus.pc};
        n_cmp++;
        if (o !== 35'h0) begin n_bad++; $display("FAIL rst_exec_async got=%h exp=0", o); end
        @(negedge clk); reset = 1'b0;
        run(16, 0);
        for (int t = 0; t < 16; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL rst_exec_rerun t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
        end
    endtask

    task automatic test_nop_wrap();
        for (int a = 0; a < 16; a++) mem_m[a] = 16'h0000;
        load(); model(40); run(40, 0);
        for (int t = 0; t < 40; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL nop_wrap t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
        end
        n_cmp++;
        if (got[30][3:0] !== 4'd15 || got[31][3:0] !== 4'd0 || got[39][34] !== 1'b1) begin
            n_bad++; $display("FAIL nop_wrap_pc pc30=%0d pc31=%0d busy=%b exp 15/0/1",
                              got[30][3:0], got[31][3:0], got[39][34]);
        end
        pulse_reset();
    endtask

    task automatic test_ldi_wrap();
        for (int a = 0; a < 16; a++) mem_m[a] = 16'h0000;
        mem_m[0] = 16'hBA98; mem_m[15] = 16'h1400;
        load(); model(40); run(40, 0);
        for (int t = 0; t < 40; t++) begin
            n_cmp++;
            if (got[t] !== expv[t]) begin
                n_bad++; $display("FAIL ldi_wrap t=%0d got=%h exp=%h", t, got[t], expv[t]);
            end
        end
        n_cmp++;
        if (got[32][32] !== 1'b1 || got[32][19:4] !== 16'hBA98 || got[33][3:0] !== 4'd1) begin
            n_bad++; $display("FAIL ldi_wrap_imm wr=%b d_in=%h pc=%0d exp 1/ba98/1",
                              got[32][32], got[32][19:4], got[33][3:0]);
        end
        pulse_reset();
    endtask

    task automatic test_random();
        logic [3:0] nopc [10];
        int p, k;
        nopc = '{4'h0, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 16; a++) mem_m[a] = 16'($urandom);
            p = 0;
            k = $urandom_range(3, 10);
            for (int i = 0; i < k && p < 13; i++) begin
                case ($urandom_range(0, 2))
                    0: begin mem_m[p] = {4'h1, 12'($urandom)}; mem_m[p+1] = 16'($urandom); p += 2; end
                    1: begin mem_m[p] = {2'b01, 2'($urandom), 12'($urandom)}; p++; end
                    default: begin mem_m[p] = {nopc[$urandom_range(0, 9)], 12'($urandom)}; p++; end
                endcase
            end
            mem_m[p] = {4'hF, 12'($urandom)};
            load(); model(60); run(60, 0);
            for (int t = 0; t < 60; t++) begin
                n_cmp++;
                if (got[t] !== expv[t]) begin
                    n_bad++; $display("FAIL random it=%0d t=%0d got=%h exp=%h", it, t, got[t], expv[t]);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        test_reset();
        test_program();
        test_prog_we_busy();
        test_start_busy();
        test_reset_exec();
        test_nop_wrap();
        test_ldi_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/reg_alu_seq.md
# reg_alu_seq

Instruction sequencer that sits directly upstream of `reg_alu` and drives its control and data inputs (`sel`, `wr`, `op`, `rd_addr_a`, `rd_addr_b`, `wr_addr`, `d_in`). It holds a small program memory loaded over a write port. On `start` it fetches, decodes and issues one register-file/ALU operation at a time until it executes HALT. It replaces hand-written test vectors with a programmable control stage.

## Interface
- `DATA_W`, 16, datapath and instruction width
- `RA_W`, 3, register address width (8 registers)
- `PC_W`, 4, program counter width (program memory depth 2^PC_W = 16 words)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin execution at address 0; sampled only in IDLE
- `prog_we`  in  1  program memory write enable; honoured only when `busy`=0
- `prog_addr`  in  PC_W  program memory write address
- `prog_data`  in  DATA_W  program memory write data
- `sel`  out  1  to reg_alu: 1 = write ALU result, 0 = write `d_in`
- `wr`  out  1  to reg_alu: register write enable
- `op`  out  2  to reg_alu: ALU operation
- `rd_addr_a`  out  RA_W  to reg_alu: read port A address
- `rd_addr_b`  out  RA_W  to reg_alu: read port B address
- `wr_addr`  out  RA_W  to reg_alu: write address
- `d_in`  out  DATA_W  to reg_alu: immediate write data
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after HALT
- `pc`  out  PC_W  current program counter

## Operation
- Instruction word layout:
  - [15:12] opcode
  - [11:9] destination, driven onto `wr_addr`
  - [8:6] source A, driven onto `rd_addr_a`
  - [5:3] source B, driven onto `rd_addr_b`
  - [2:0] ignored
- Opcodes:
  - 0000 NOP.
  - 0001 LDI: the next program word is the immediate; write it to the destination register.
  - 01xx ALU: `op` = opcode[1:0]; write the ALU result to the destination register.
  - 1111 HALT.
  - All other opcodes execute as NOP.
- Program memory is a register array (16×16). A write takes effect at the rising edge while `prog_we`=1 and `busy`=0; otherwise it is ignored. Reads are combinational from `pc`. Reset does not clear the memory.
- FSM states: IDLE, FETCH, DECODE, IMM, EXEC, DONE.
  - IDLE: if `start`=1, then `pc`←0 and go to FETCH.
  - FETCH: `ir`←mem[`pc`], `pc`←`pc`+1, go to DECODE.
  - DECODE: HALT→DONE; LDI→IMM; ALU→EXEC; otherwise→FETCH.
  - IMM: `d_in`=mem[`pc`], `sel`=0, `wr`=1, `pc`←`pc`+1, go to FETCH.
  - EXEC: `sel`=1, `wr`=1, `op`=ir[13:12], go to FETCH.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Control outputs are Moore outputs decoded from state and `ir`:
  - `rd_addr_a`, `rd_addr_b` and `wr_addr` always reflect `ir` fields, so reg_alu read data is observable in every state.
  - Outside IMM/EXEC: `wr`=0, `sel`=0, `op`=0, `d_in`=0.
- `pc` wraps modulo 2^PC_W (15+1 = 0), including when an LDI opcode sits at address 15 and its immediate is read from address 0. A program with no HALT runs indefinitely.
- `start` while `busy`=1 is ignored. `start` held high through DONE re-launches the program from IDLE on the following cycle.

## Timing
- Reset values:
  - state = IDLE; `pc`=0; `ir`=0
  - `sel`=0, `wr`=0, `op`=0, `d_in`=0, `busy`=0, `done`=0
  - `rd_addr_a`=0, `rd_addr_b`=0, `wr_addr`=0
- Reset asserted mid-program: outputs return to reset values immediately (asynchronously). Any write in progress is not issued.
- Cycles per instruction: NOP = 2, LDI = 3, ALU = 3, HALT = 3 (FETCH, DECODE, DONE).
- `wr` is high for exactly one cycle per LDI/ALU. reg_alu captures the write at the rising edge that ends that cycle, so the result is readable from the following cycle.
- `start` sampled at edge N → FETCH during cycle N+1; the first write occurs no earlier than the edge ending cycle N+3.
- Back-to-back instructions: an ALU instruction whose source is the destination of the immediately preceding instruction reads the updated value, because its EXEC cycle is at least 2 cycles after the prior write.

## Test plan
- Load program {0x1600 (LDI r3), 0xCDEF, 0x1E00 (LDI r7), 0x3210, 0x4AF8 (ADD r5←r3,r7), 0xF000 (HALT)}, then pulse `start` → `wr` pulses 3 times:
  - `wr_addr` 3 with `d_in` 0xCDEF (`sel`=0)
  - `wr_addr` 7 with `d_in` 0x3210 (`sel`=0)
  - `wr_addr` 5 with `sel`=1, `op`=00
  - then `done` pulses once and `busy` falls the next cycle (9+3 = 12 cycles after FETCH entry).
- Program memory all 0x0000 (NOP) → `wr` never asserts; `pc` wraps 15→0 and execution continues; `busy` stays high.
- Assert `prog_we` to address 0 with 0xF000 while `busy`=1 → memory is unchanged; a readback run proves the original program still executes.
- Assert `reset` during an EXEC cycle → `wr` drops immediately, state returns to IDLE with `pc`=0, and the program memory is retained (a rerun produces the same result).
- LDI at address 15 with the immediate 0xBA98 at address 0 → write of 0xBA98 issued and `pc` = 1 afterwards.
- Pulse `start` while `busy`=1 → no effect on `pc` or the instruction sequence.
